nr4sdp_recode_core: RTL and testbench
=====================================

# nr4sdp_recode_core

Registered NR4SD+ recoder for the 16-bit signed multiplier datapath. It converts the 16-bit two's-complement multiplier into eight radix-4 digits. Digits 0..6 are NR4SD+ digits in {-1,0,+1,+2}. Digit 7, the most significant, is a Modified-Booth digit in {-2..+2}. Per digit it produces the partial-product select lines and the 32-bit correction constant COR that the partial-product generators and the adder tree consume.

## Interface
- No parameters. Widths are fixed: 16-bit operand, 7 NR4SD+ digits, 32-bit COR.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  qualifies a; sampled on each rising clk.
- a  in  16  multiplier operand, two's complement.
- out_valid  out  1  outputs hold a result for the operand accepted on the previous edge.
- nm  out  7  nm[j] is the n⁻ bit at weight 2j of digit j.
- np  out  7  np[j] is the n⁺ bit at weight 2j+1 of digit j.
- one_p  out  7  digit j = +1.
- one_m  out  7  digit j = -1.
- two_p  out  7  digit j = +2.
- sign  out  1  top MB digit is strictly negative.
- one  out  1  top MB digit magnitude is 1.
- two  out  1  top MB digit magnitude is 2.
- cor  out  32  correction constant for the adder tree.

## Operation
- Carry chain: c0 = 0. For j = 0..6:
  - Low half-adder (HA*): nm[j] = a[2j] ^ c_2j; c_2j+1 = a[2j] | c_2j.
  - High half-adder (HA): np[j] = a[2j+1] ^ c_2j+1; c_2j+2 = a[2j+1] & c_2j+1.
- Digit j value = 2·np[j] − nm[j].
- Top digit value y7 = −2·a[15] + a[14] + c14.
  - one = a[14] ^ c14.
  - two = (a[15] & ~a[14] & ~c14) | (~a[15] & a[14] & c14).
  - sign = a[15] & ~(a[14] & c14). sign is 0 for a zero digit.
- Invariant: Σ_j digit_j·4^j = signed value of a, exactly.
- Select lines, per digit:
  - one_p = nm & np.
  - one_m = nm & ~np.
  - two_p = np & ~nm.
  - At most one select is high per digit. All low means digit 0.
- Partial-product contract for downstream generators:
  - Each PP is 17 bits: ±B, 2B, or 0, sign-extended.
  - A negative PP is formed as the bitwise inverse of sext(B) or 2B.
  - The PP MSB (bit 16) is inverted before summation.
  - PP_j is weighted by 4^j.
- COR = 0xAAAB_0000 + Σ_{j=0..6} one_m[j]·2^(2j) + sign·2^14, mod 2^32.
  - 0xAAAB_0000 equals −Σ_{j=0..7} 2^(16+2j) mod 2^32 and compensates the inverted MSBs.
  - The added bits supply the +1 for each one's-complement negation.
  - Correction bits never overlap, so the low 16 bits are a plain OR.
- Product = (Σ PP_j·4^j + cor) mod 2^32.

## Timing
- Latency: 1 cycle. When in_valid = 1 at edge k, all outputs reflect that a from edge k until edge k+1, and out_valid = 1.
- When in_valid = 0 at an edge, out_valid goes to 0 and the data outputs hold their previous values.
- Full throughput: a new operand is accepted every cycle, back-to-back, with no stall.
- Reset: when rst = 1 at an edge, out_valid = 0 and nm, np, one_p, one_m, two_p, sign, one, two, cor all = 0. rst takes priority over in_valid.
- The first valid result appears one edge after an edge with rst = 0 and in_valid = 1.
- Reset mid-stream discards the in-flight result.
- No combinational path from input to output.

## Test plan
- a = 0x0B1E (2846) -> nm = 7'b1110010, np = 7'b1000101, one_p = 7'b1000000, one_m = 7'b0110010, two_p = 7'b0000101, sign/one/two = 0/0/0, cor = 0xAAAB0504. With B = 15953, the full sum is 45402238.
- a = 0x8000 -> nm = np = 0, sign = 1, one = 0, two = 1, cor = 0xAAAB4000.
- a = 0xFFFF -> nm = 7'b0000001, np = 0, one_m = 7'b0000001, sign/one/two = 0/0/0, cor = 0xAAAB0001.
- a = 0x7FFF -> one_m[0] = 1, digits 1..6 zero, two = 1, sign = 0, cor = 0xAAAB0001. a = 0x0000 -> all selects 0, cor = 0xAAAB0000.
- Handshake: back-to-back valid operands give one result per cycle with 1-cycle lag. rst asserted with in_valid = 1 -> next cycle out_valid = 0 and all outputs 0.
- Random sweep over all 65536 values of a, with random B: Σ digits·4^j = a, and the PP sum plus cor equals a·B mod 2^32.

Source files
------------

// File: rtl/nr4sdp_recode_core.sv
// nr4sdp_recode_core
// Registered NR4SD+ recoder for a 16-bit two's-complement multiplier.
// Digits 0..6 are NR4SD+ digits in {-1,0,+1,+2}; digit 7 is a Modified-Booth
// digit in {-2..+2}. Outputs carry the per-digit partial-product selects and
// the 32-bit correction constant consumed by the adder tree.
module nr4sdp_recode_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    output logic        out_valid,
    output logic [6:0]  nm,
    output logic [6:0]  np,
    output logic [6:0]  one_p,
    output logic [6:0]  one_m,
    output logic [6:0]  two_p,
    output logic        sign,
    output logic        one,
    output logic        two,
    output logic [31:0] cor
);

    logic [6:0]  nm_c;
    logic [6:0]  np_c;
    logic [6:0]  one_p_c;
    logic [6:0]  one_m_c;
    logic [6:0]  two_p_c;
    logic        sign_c;
    logic        one_c;
    logic        two_c;
    logic [31:0] cor_c;
    logic        carry;

    // Carry chain of alternating HA*/HA cells, top MB digit and COR assembly
    always_comb begin
        nm_c    = '0;
        np_c    = '0;
        one_p_c = '0;
        one_m_c = '0;
        two_p_c = '0;
        sign_c  = 1'b0;
        one_c   = 1'b0;
        two_c   = 1'b0;
        cor_c   = 32'hAAAB_0000;
        carry   = 1'b0;
        // A single running carry keeps the chain inside one process
        for (int unsigned j = 0; j < 7; j++) begin
            nm_c[j] = a[2*j] ^ carry;
            carry   = a[2*j] | carry;
            np_c[j] = a[2*j+1] ^ carry;
            carry   = a[2*j+1] & carry;
        end
        // carry now holds c14
        one_c   = a[14] ^ carry;
        two_c   = (a[15] & ~a[14] & ~carry) | (~a[15] & a[14] & carry);
        sign_c  = a[15] & ~(a[14] & carry);
        one_p_c = nm_c & np_c;
        one_m_c = nm_c & ~np_c;
        two_p_c = np_c & ~nm_c;
        // Negation +1 bits sit at distinct even positions below bit 16
        for (int unsigned j = 0; j < 7; j++) begin
            cor_c[2*j] = one_m_c[j];
        end
        cor_c[14] = sign_c;
    end

    // Output register: reset clears everything, invalid cycles hold data
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            nm        <= '0;
            np        <= '0;
            one_p     <= '0;
            one_m     <= '0;
            two_p     <= '0;
            sign      <= 1'b0;
            one       <= 1'b0;
            two       <= 1'b0;
            cor       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                nm    <= nm_c;
                np    <= np_c;
                one_p <= one_p_c;
                one_m <= one_m_c;
                two_p <= two_p_c;
                sign  <= sign_c;
                one   <= one_c;
                two   <= two_c;
                cor   <= cor_c;
            end
        end
    end

endmodule

// File: tb/tb_nr4sdp_recode_core.sv
// Testbench for nr4sdp_recode_core: directed vectors, handshake scenarios and
// an exhaustive operand sweep checked against the digit and product contracts.
module tb_nr4sdp_recode_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic        out_valid;
    logic [6:0]  nm, np, one_p, one_m, two_p;
    logic        sign, one, two;
    logic [31:0] cor;

    int checks;
    int passed;

    nr4sdp_recode_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .nm        (nm),
        .np        (np),
        .one_p     (one_p),
        .one_m     (one_m),
        .two_p     (two_p),
        .sign      (sign),
        .one       (one),
        .two       (two),
        .cor       (cor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [15:0] a;
        logic [6:0]  nm, np, op, om, tp;
        logic        s, o, t;
        logic [31:0] cor;
    } vec_t;

    // Drive one operand at the falling edge, then settle just past the next rising edge
    task automatic drive(input logic v, input logic [15:0] x);
        @(negedge clk);
        in_valid = v;
        a        = x;
        @(posedge clk);
        #1;
    endtask

    // Product formed exactly as downstream PP generators and adder tree would
    function automatic logic [31:0] pp_product(input logic [6:0] op, input logic [6:0] om,
                                               input logic [6:0] tp, input logic s, input logic o,
                                               input logic t, input logic [31:0] c,
                                               input logic [15:0] b);
        logic [16:0] bx, b2, pp;
        logic [31:0] acc;
        bx  = {b[15], b};
        b2  = {b, 1'b0};
        acc = c;
        for (int j = 0; j < 7; j++) begin
            if (op[j])      pp = bx;
            else if (tp[j]) pp = b2;
            else if (om[j]) pp = ~bx;
            else            pp = '0;
            pp[16] = ~pp[16];
            acc = acc + ({15'b0, pp} << (2*j));
        end
        if (o)      pp = s ? ~bx : bx;
        else if (t) pp = s ? ~b2 : b2;
        else        pp = '0;
        pp[16] = ~pp[16];
        acc = acc + ({15'b0, pp} << 14);
        return acc;
    endfunction

    // Signed value represented by the recoded digit set
    function automatic int digit_sum(input logic [6:0] n_m, input logic [6:0] n_p,
                                     input logic s, input logic o, input logic t);
        int acc;
        int w;
        int y7;
        acc = 0;
        w   = 1;
        for (int j = 0; j < 7; j++) begin
            acc = acc + (2 * int'(n_p[j]) - int'(n_m[j])) * w;
            w   = w * 4;
        end
        y7 = o ? 1 : (t ? 2 : 0);
        if (s) y7 = -y7;
        return acc + y7 * 16384;
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0B1E;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if ({nm, np, one_p, one_m, two_p, sign, one, two} !== 38'h0)
            $display("FAIL reset_sel: got %h want 0", {nm, np, one_p, one_m, two_p, sign, one, two});
        else passed++;
        checks++;
        if (cor !== 32'h0) $display("FAIL reset_cor: got %h want 00000000", cor);
        else passed++;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_vectors();
        vec_t v[7];
        logic [37:0] got, exp;
        logic [31:0] prod;
        v[0] = '{16'h0B1E, 7'b1110010, 7'b1000101, 7'b1000000, 7'b0110010, 7'b0000101, 1'b0, 1'b0, 1'b0, 32'hAAAB0504};
        v[1] = '{16'h8000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 1'b1, 1'b0, 1'b1, 32'hAAAB4000};
        v[2] = '{16'hFFFF, 7'b0000001, 7'b0, 7'b0, 7'b0000001, 7'b0, 1'b0, 1'b0, 1'b0, 32'hAAAB0001};
        v[3] = '{16'h7FFF, 7'b0000001, 7'b0, 7'b0, 7'b0000001, 7'b0, 1'b0, 1'b0, 1'b1, 32'hAAAB0001};
        v[4] = '{16'h0000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 1'b0, 1'b0, 1'b0, 32'hAAAB0000};
        v[5] = '{16'h0001, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0, 7'b0, 1'b0, 1'b0, 1'b0, 32'hAAAB0000};
        v[6] = '{16'h0002, 7'b0, 7'b0000001, 7'b0, 7'b0, 7'b0000001, 1'b0, 1'b0, 1'b0, 32'hAAAB0000};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, v[i].a);
            checks++;
            if (out_valid !== 1'b1) $display("FAIL vec_valid a=%h: got %b want 1", v[i].a, out_valid);
            else passed++;
            got = {nm, np, one_p, one_m, two_p, sign, one, two};
            exp = {v[i].nm, v[i].np, v[i].op, v[i].om, v[i].tp, v[i].s, v[i].o, v[i].t};
            checks++;
            if (got !== exp) $display("FAIL vec_sel a=%h: got %b want %b", v[i].a, got, exp);
            else passed++;
            checks++;
            if (cor !== v[i].cor) $display("FAIL vec_cor a=%h: got %h want %h", v[i].a, cor, v[i].cor);
            else passed++;
            if (i == 0) begin
                prod = pp_product(one_p, one_m, two_p, sign, one, two, cor, 16'd15953);
                checks++;
                if (prod !== 32'd45402238) $display("FAIL vec_product: got %0d want 45402238", prod);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'h0B1E);
        checks++;
        if ({out_valid, cor} !== {1'b1, 32'hAAAB0504})
            $display("FAIL b2b_0: got %b/%h want 1/aaab0504", out_valid, cor);
        else passed++;
        drive(1'b1, 16'h8000);
        checks++;
        if ({out_valid, cor, sign} !== {1'b1, 32'hAAAB4000, 1'b1})
            $display("FAIL b2b_1: got %b/%h/%b want 1/aaab4000/1", out_valid, cor, sign);
        else passed++;
        drive(1'b1, 16'hFFFF);
        checks++;
        if ({out_valid, cor, nm} !== {1'b1, 32'hAAAB0001, 7'b0000001})
            $display("FAIL b2b_2: got %b/%h/%b want 1/aaab0001/0000001", out_valid, cor, nm);
        else passed++;
    endtask

    task automatic test_hold();
        drive(1'b0, 16'h0B1E);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL hold_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if ({cor, nm, one_m} !== {32'hAAAB0001, 7'b0000001, 7'b0000001})
            $display("FAIL hold_data: got %h/%b/%b want aaab0001/0000001/0000001", cor, nm, one_m);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 16'h0B1E);
        checks++;
        if (cor !== 32'hAAAB0504) $display("FAIL mid_pre: got %h want aaab0504", cor);
        else passed++;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h8000;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, cor, nm, np, sign, two} !== 48'h0)
            $display("FAIL mid_reset: got %b/%h/%b/%b/%b/%b want all 0", out_valid, cor, nm, np, sign, two);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h8000);
        checks++;
        if ({out_valid, cor} !== {1'b1, 32'hAAAB4000})
            $display("FAIL mid_first: got %b/%h want 1/aaab4000", out_valid, cor);
        else passed++;
    endtask

    task automatic test_sweep();
        logic [15:0] x, b;
        logic [31:0] prod, exp;
        int          ds, xs;
        logic        ok;
        for (int i = 0; i < 65536; i++) begin
            x = 16'(i);
            b = 16'($urandom);
            drive(1'b1, x);
            xs   = int'($signed(x));
            exp  = 32'(xs * int'($signed(b)));
            ds   = digit_sum(nm, np, sign, one, two);
            prod = pp_product(one_p, one_m, two_p, sign, one, two, cor, b);
            ok   = (out_valid === 1'b1) && (ds == xs) && (prod === exp)
                && (((one_p & one_m) | (one_p & two_p) | (one_m & two_p)) === 7'b0);
            checks++;
            if (!ok)
                $display("FAIL sweep a=%h b=%h: got digits=%0d prod=%h valid=%b want digits=%0d prod=%h valid=1",
                         x, b, ds, prod, out_valid, xs, exp);
            else passed++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
